lcd_timing_gen: RTL and testbench

LCD_TIMING_GEN -- requirements
Module: lcd_timing_gen

---
 rtl/lcd_timing_pkg.sv | 63 ++++++
 rtl/lcd_pattern.sv | 77 +++++++
 rtl/lcd_timing_gen.sv | 164 ++++++++++++++++
 tb/tb_lcd_timing_gen.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared timing constants and encodings for the 800x480 LCD timing generator.
// Horizontal timing is common to all modes; vertical timing is looked up per mode.
package lcd_timing_pkg;

  localparam logic [10:0] HActive    = 11'd800;
  localparam logic [10:0] HFp        = 11'd40;
  localparam logic [10:0] HSync      = 11'd48;
  localparam logic [10:0] HBp        = 11'd88;
  localparam logic [10:0] HTotal     = HActive + HFp + HSync + HBp;
  localparam logic [10:0] HSyncStart = HActive + HFp;
  localparam logic [10:0] HSyncEnd   = HSyncStart + HSync;

  localparam logic [9:0]  VActive    = 10'd480;

  localparam int unsigned BarWidth   = 100;
  localparam logic [5:0]  CompMax    = 6'd63;

  typedef enum logic [1:0] {
    VmNtsc60 = 2'd0,
    VmPal50  = 2'd1,
    VmMono72 = 2'd2,
    VmAlias  = 2'd3
  } vmode_e;

  typedef enum logic [1:0] {
    PatBars     = 2'd0,
    PatGrid     = 2'd1,
    PatGradient = 2'd2,
    PatBlack    = 2'd3
  } pattern_e;

  typedef struct packed {
    logic [9:0] vfp;
    logic [9:0] vsync;
    logic [9:0] vbp;
    logic [9:0] vtotal;
  } vtiming_t;

  localparam vtiming_t VTimingNtsc60 = '{vfp: 10'd13,  vsync: 10'd3, vbp: 10'd29, vtotal: 10'd525};
  localparam vtiming_t VTimingPal50  = '{vfp: 10'd118, vsync: 10'd3, vbp: 10'd29, vtotal: 10'd630};
  localparam vtiming_t VTimingMono72 = '{vfp: 10'd8,   vsync: 10'd3, vbp: 10'd9,  vtotal: 10'd500};

  // The reserved encoding runs as NTSC-60.
  function automatic vmode_e vmode_sanitize(logic [1:0] m);
    vmode_e mode;
    mode = vmode_e'(m);
    if (mode == VmAlias) begin
      mode = VmNtsc60;
    end
    return mode;
  endfunction

  function automatic vtiming_t vtiming_lookup(vmode_e m);
    vtiming_t t;
    case (m)
      VmPal50:  t = VTimingPal50;
      VmMono72: t = VTimingMono72;
      default:  t = VTimingNtsc60;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/lcd_pattern.sv
// Combinational test-pattern generator: maps a raster position and pattern select to RGB.
// Produces black outside the 800x480 active area.
module lcd_pattern
  import lcd_timing_pkg::*;
(
  input  logic [10:0] h_i,
  input  logic [9:0]  v_i,
  input  pattern_e    pattern_i,
  output logic [5:0]  r_o,
  output logic [5:0]  g_o,
  output logic [5:0]  b_o
);

  logic       active;
  logic [2:0] bar_idx;
  logic [2:0] bar_rgb;
  logic       grid_on;

  assign active  = (h_i < HActive) && (v_i < VActive);
  assign grid_on = (h_i[4:0] == 5'd0) || (v_i[4:0] == 5'd0);

  // Bar index is the number of 100-pixel boundaries already passed.
  always_comb begin
    bar_idx = 3'd0;
    for (int i = 1; i < 8; i++) begin
      if (h_i >= 11'(i * BarWidth)) begin
        bar_idx = bar_idx + 3'd1;
      end
    end
  end

  // {r,g,b} on/off per bar, left to right.
  always_comb begin
    bar_rgb = 3'b000;
    unique case (bar_idx)
      3'd0: bar_rgb = 3'b111;
      3'd1: bar_rgb = 3'b110;
      3'd2: bar_rgb = 3'b011;
      3'd3: bar_rgb = 3'b010;
      3'd4: bar_rgb = 3'b101;
      3'd5: bar_rgb = 3'b100;
      3'd6: bar_rgb = 3'b001;
      3'd7: bar_rgb = 3'b000;
    endcase
  end

  always_comb begin
    r_o = '0;
    g_o = '0;
    b_o = '0;
    if (active) begin
      unique case (pattern_i)
        PatBars: begin
          r_o = {6{bar_rgb[2]}};
          g_o = {6{bar_rgb[1]}};
          b_o = {6{bar_rgb[0]}};
        end
        PatGrid: begin
          r_o = grid_on ? CompMax : 6'd0;
          g_o = grid_on ? CompMax : 6'd0;
          b_o = grid_on ? CompMax : 6'd0;
        end
        PatGradient: begin
          r_o = h_i[9:4];
          g_o = v_i[8:3];
          b_o = CompMax - h_i[9:4];
        end
        PatBlack: begin
          r_o = '0;
          g_o = '0;
          b_o = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_timing_gen.sv
// 800x480 LCD timing generator with selectable vertical timing and built-in test patterns.
// All outputs are registered one clock behind the raster counters and mutually aligned.
module lcd_timing_gen
  import lcd_timing_pkg::*;
(
  input  logic        clk_pixel,
  input  logic        por_n,
  input  logic        enable,
  input  logic [1:0]  vmode,
  input  logic [1:0]  pattern,
  output logic        lcd_hs_n,
  output logic        lcd_vs_n,
  output logic        lcd_de,
  output logic [5:0]  lcd_r,
  output logic [5:0]  lcd_g,
  output logic [5:0]  lcd_b,
  output logic [10:0] hcnt,
  output logic [9:0]  vcnt,
  output logic        frame_start
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e      state_q, state_d;
  vmode_e      mode_q, mode_d;
  logic [10:0] h_q, h_d;
  logic [9:0]  v_q, v_d;

  vtiming_t    vt;
  logic        h_last, v_last, run;
  logic [9:0]  vs_start, vs_end;
  logic [5:0]  pat_r, pat_g, pat_b;

  logic        hs_n_q, hs_n_d;
  logic        vs_n_q, vs_n_d;
  logic        de_q, de_d;
  logic [5:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic [10:0] hcnt_q, hcnt_d;
  logic [9:0]  vcnt_q, vcnt_d;
  logic        fs_q, fs_d;

  assign vt       = vtiming_lookup(mode_q);
  assign h_last   = (h_q == HTotal - 11'd1);
  assign v_last   = (v_q == vt.vtotal - 10'd1);
  assign vs_start = VActive + vt.vfp;
  assign vs_end   = vs_start + vt.vsync;
  // Counters hold a valid raster position only once the run state has been entered.
  assign run      = enable && (state_q == StRun);

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      StIdle: begin
        h_d = '0;
        v_d = '0;
        if (enable) begin
          state_d = StRun;
          mode_d  = vmode_sanitize(vmode);
        end
      end
      StRun: begin
        if (!enable) begin
          state_d = StIdle;
          h_d     = '0;
          v_d     = '0;
        end else if (h_last) begin
          h_d = '0;
          if (v_last) begin
            v_d    = '0;
            mode_d = vmode_sanitize(vmode);
          end else begin
            v_d = v_q + 10'd1;
          end
        end else begin
          h_d = h_q + 11'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk_pixel or negedge por_n) begin
    if (!por_n) begin
      state_q <= StIdle;
      mode_q  <= VmNtsc60;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  lcd_pattern u_pattern (
    .h_i       (h_q),
    .v_i       (v_q),
    .pattern_i (pattern_e'(pattern)),
    .r_o       (pat_r),
    .g_o       (pat_g),
    .b_o       (pat_b)
  );

  always_comb begin
    hs_n_d = 1'b1;
    vs_n_d = 1'b1;
    de_d   = 1'b0;
    r_d    = '0;
    g_d    = '0;
    b_d    = '0;
    hcnt_d = '0;
    vcnt_d = '0;
    fs_d   = 1'b0;
    if (run) begin
      hs_n_d = !((h_q >= HSyncStart) && (h_q < HSyncEnd));
      vs_n_d = !((v_q >= vs_start) && (v_q < vs_end));
      de_d   = (h_q < HActive) && (v_q < VActive);
      r_d    = pat_r;
      g_d    = pat_g;
      b_d    = pat_b;
      hcnt_d = h_q;
      vcnt_d = v_q;
      fs_d   = (h_q == 11'd0) && (v_q == 10'd0);
    end
  end

  always_ff @(posedge clk_pixel or negedge por_n) begin
    if (!por_n) begin
      hs_n_q <= 1'b1;
      vs_n_q <= 1'b1;
      de_q   <= 1'b0;
      r_q    <= '0;
      g_q    <= '0;
      b_q    <= '0;
      hcnt_q <= '0;
      vcnt_q <= '0;
      fs_q   <= 1'b0;
    end else begin
      hs_n_q <= hs_n_d;
      vs_n_q <= vs_n_d;
      de_q   <= de_d;
      r_q    <= r_d;
      g_q    <= g_d;
      b_q    <= b_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      fs_q   <= fs_d;
    end
  end

  assign lcd_hs_n    = hs_n_q;
  assign lcd_vs_n    = vs_n_q;
  assign lcd_de      = de_q;
  assign lcd_r       = r_q;
  assign lcd_g       = g_q;
  assign lcd_b       = b_q;
  assign hcnt        = hcnt_q;
  assign vcnt        = vcnt_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Directed bench for lcd_timing_gen: reset, line/frame timing per mode, patterns, enable and
// asynchronous reset behaviour, all against hand-computed values.
module tb_lcd_timing_gen;

  logic        clk_pixel;
  logic        por_n;
  logic        enable;
  logic [1:0]  vmode;
  logic [1:0]  pattern;
  logic        lcd_hs_n;
  logic        lcd_vs_n;
  logic        lcd_de;
  logic [5:0]  lcd_r;
  logic [5:0]  lcd_g;
  logic [5:0]  lcd_b;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic        frame_start;

  int n_vec  = 0;
  int n_miss = 0;

  localparam int FrameBudget = 700 * 976;

  lcd_timing_gen dut (
    .clk_pixel   (clk_pixel),
    .por_n       (por_n),
    .enable      (enable),
    .vmode       (vmode),
    .pattern     (pattern),
    .lcd_hs_n    (lcd_hs_n),
    .lcd_vs_n    (lcd_vs_n),
    .lcd_de      (lcd_de),
    .lcd_r       (lcd_r),
    .lcd_g       (lcd_g),
    .lcd_b       (lcd_b),
    .hcnt        (hcnt),
    .vcnt        (vcnt),
    .frame_start (frame_start)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rgb(input int r, input int g, input int b);
    return r * 4096 + g * 64 + b;
  endfunction

  function automatic int cur_rgb();
    return rgb(int'(lcd_r), int'(lcd_g), int'(lcd_b));
  endfunction

  task automatic step();
    @(posedge clk_pixel);
    @(negedge clk_pixel);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_de"}, int'(lcd_de), 0);
    check({tag, "_hs_n"}, int'(lcd_hs_n), 1);
    check({tag, "_vs_n"}, int'(lcd_vs_n), 1);
    check({tag, "_rgb"}, cur_rgb(), 0);
    check({tag, "_fs"}, int'(frame_start), 0);
    check({tag, "_hcnt"}, int'(hcnt), 0);
    check({tag, "_vcnt"}, int'(vcnt), 0);
  endtask

  task automatic goto_pos(input string tag, input int h, input int v);
    bit found = 1'b0;
    for (int n = 0; n < FrameBudget; n++) begin
      if (int'(hcnt) == h && int'(vcnt) == v) begin
        found = 1'b1;
        break;
      end
      step();
    end
    check({tag, "_reached"}, int'(found), 1);
  endtask

  // Runs until the next frame_start sample; optionally changes vmode mid-frame.
  task automatic run_frame(input int chg_v, input int new_mode, output int lines,
                           output int vs_lo, output int vs_hi, output int vs_bad);
    int  vmax    = int'(vcnt);
    bit  found   = 1'b0;
    logic prev_vs = lcd_vs_n;
    vs_lo  = -1;
    vs_hi  = -1;
    vs_bad = 0;
    for (int n = 0; n < FrameBudget; n++) begin
      step();
      if (frame_start) begin
        found = 1'b1;
        break;
      end
      if (int'(vcnt) > vmax) vmax = int'(vcnt);
      if (!lcd_vs_n) begin
        if (vs_lo < 0) vs_lo = int'(vcnt);
        vs_hi = int'(vcnt);
      end
      if (lcd_vs_n != prev_vs && hcnt != 11'd0) vs_bad++;
      prev_vs = lcd_vs_n;
      if (int'(vcnt) == chg_v && hcnt == 11'd0) vmode = 2'(new_mode);
    end
    lines = found ? vmax + 1 : 0;
  endtask

  task automatic check_frame(input string tag, input int lines, input int vs_lo, input int vs_hi,
                             input int vs_bad, input int exp_lines, input int exp_vs_lo);
    check({tag, "_lines"}, lines, exp_lines);
    check({tag, "_vs_first"}, vs_lo, exp_vs_lo);
    check({tag, "_vs_last"}, vs_hi, exp_vs_lo + 2);
    check({tag, "_vs_mid_line"}, vs_bad, 0);
  endtask

  initial begin
    int lines, vs_lo, vs_hi, vs_bad;
    int de_cnt, hs_cnt, hs_first, fs_cnt, h_bad;

    por_n   = 1'b1;
    enable  = 1'b1;
    vmode   = 2'd0;
    pattern = 2'd0;
    #1 por_n = 1'b0;
    #2 check_idle("reset_async");
    step();
    step();
    check_idle("reset_held");

    por_n = 1'b1;
    step();
    check("start_c1_de", int'(lcd_de), 0);
    check("start_c1_fs", int'(frame_start), 0);
    step();
    check("start_c2_de", int'(lcd_de), 1);
    check("start_c2_fs", int'(frame_start), 1);
    check("start_c2_hcnt", int'(hcnt), 0);
    check("start_c2_vcnt", int'(vcnt), 0);

    // First line: DE width, HS placement, bar colours.
    de_cnt = 0; hs_cnt = 0; hs_first = -1; fs_cnt = 0; h_bad = 0;
    for (int i = 0; i < 976; i++) begin
      if (int'(hcnt) != i || vcnt != 10'd0) h_bad++;
      if (lcd_de) de_cnt++;
      if (frame_start) fs_cnt++;
      if (!lcd_hs_n) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(hcnt);
      end
      if (i == 0)   check("bar_h0", cur_rgb(), rgb(63, 63, 63));
      if (i == 99)  check("bar_h99", cur_rgb(), rgb(63, 63, 63));
      if (i == 100) check("bar_h100", cur_rgb(), rgb(63, 63, 0));
      if (i == 599) check("bar_h599", cur_rgb(), rgb(63, 0, 0));
      if (i == 799) begin
        check("bar_h799", cur_rgb(), 0);
        check("bar_h799_de", int'(lcd_de), 1);
      end
      if (i == 800) begin
        check("bar_h800", cur_rgb(), 0);
        check("bar_h800_de", int'(lcd_de), 0);
      end
      step();
    end
    check("line_hcnt_seq", h_bad, 0);
    check("line_de_width", de_cnt, 800);
    check("line_hs_width", hs_cnt, 48);
    check("line_hs_start", hs_first, 840);
    check("line_fs_pulses", fs_cnt, 1);

    // Frame sequence: mode changes land mid-frame and take effect on the next frame.
    run_frame(100, 1, lines, vs_lo, vs_hi, vs_bad);
    check_frame("f_ntsc", lines, vs_lo, vs_hi, vs_bad, 525, 493);
    run_frame(100, 2, lines, vs_lo, vs_hi, vs_bad);
    check_frame("f_pal", lines, vs_lo, vs_hi, vs_bad, 630, 598);
    run_frame(100, 3, lines, vs_lo, vs_hi, vs_bad);
    check_frame("f_mono", lines, vs_lo, vs_hi, vs_bad, 500, 488);
    run_frame(-1, 0, lines, vs_lo, vs_hi, vs_bad);
    check_frame("f_alias", lines, vs_lo, vs_hi, vs_bad, 525, 493);

    pattern = 2'd1;
    goto_pos("grid_a", 32, 1);
    check("grid_h32", cur_rgb(), rgb(63, 63, 63));
    goto_pos("grid_b", 33, 1);
    check("grid_h33", cur_rgb(), 0);
    goto_pos("grid_c", 5, 64);
    check("grid_v64", cur_rgb(), rgb(63, 63, 63));

    pattern = 2'd2;
    goto_pos("grad_a", 100, 70);
    check("grad_100_70", cur_rgb(), rgb(6, 8, 57));
    pattern = 2'd3;
    goto_pos("black", 200, 70);
    check("black_rgb", cur_rgb(), 0);
    check("black_de", int'(lcd_de), 1);

    pattern = 2'd0;
    goto_pos("en_drop", 300, 200);
    check("en_pre_rgb", cur_rgb(), rgb(0, 63, 0));
    enable = 1'b0;
    step();
    check_idle("en_low_c1");
    repeat (4) step();
    check_idle("en_low_c5");
    enable = 1'b1;
    step();
    check("reen_c1_fs", int'(frame_start), 0);
    check("reen_c1_de", int'(lcd_de), 0);
    step();
    check("reen_c2_fs", int'(frame_start), 1);
    check("reen_c2_hcnt", int'(hcnt), 0);
    check("reen_c2_vcnt", int'(vcnt), 0);
    check("reen_c2_de", int'(lcd_de), 1);

    pattern = 2'd2;
    goto_pos("grad_b", 799, 479);
    check("grad_799_479", cur_rgb(), rgb(49, 59, 14));
    step();
    check("grad_800_de", int'(lcd_de), 0);
    check("grad_800_rgb", cur_rgb(), 0);

    pattern = 2'd0;
    goto_pos("por_mid", 500, 10);
    check("por_pre_rgb", cur_rgb(), rgb(63, 0, 0));
    #2 por_n = 1'b0;
    #1 check_idle("por_async");
    step();
    step();
    por_n = 1'b1;
    step();
    check("por_c1_de", int'(lcd_de), 0);
    step();
    check("por_c2_de", int'(lcd_de), 1);
    check("por_c2_fs", int'(frame_start), 1);
    check("por_c2_hcnt", int'(hcnt), 0);
    check("por_c2_rgb", cur_rgb(), rgb(63, 63, 63));
    goto_pos("por_hs", 839, 0);
    check("por_hs_839", int'(lcd_hs_n), 1);
    step();
    check("por_hs_840", int'(lcd_hs_n), 0);
    check("por_hcnt_840", int'(hcnt), 840);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
